mshr_merge_queue: RTL and testbench

Parametrised miss status holding register for the cache miss path. Tracks up to 2**ENTRY_BITS outstanding line misses. With merging compiled in, secondary misses to an in-flight tag attach to the existing entry. Issues each miss to memory once, in allocation order, and replays every attached request in arrival order when the fill returns. Sits between the cache tag-check stage and the memory request/response interface.

---
 rtl/mshr_merge_queue_if.sv | 50 +++++
 rtl/mshr_merge_queue.sv | 205 ++++++++++++++++++++
 tb/tb_mshr_merge_queue.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mshr_merge_queue_if.sv
// Signal bundle between the MSHR, the cache tag-check stage and the memory port.
interface mshr_merge_queue_if #(
  parameter int TAG_BITS   = 20,
  parameter int DATA_BITS  = 90,
  parameter int ENTRY_BITS = 3
);
  // valid/ready: a transfer happens on a rising edge where both are high; the
  // sender holds its payload stable while valid is high and ready is low.
  logic                      alloc_valid;
  logic                      alloc_ready;
  logic [TAG_BITS-1:0]       alloc_tag;
  logic [DATA_BITS-1:0]      alloc_data;
  logic                      alloc_rw;
  logic [ENTRY_BITS-1:0]     alloc_id;
  logic                      issue_valid;
  logic                      issue_ready;
  logic [TAG_BITS-1:0]       issue_tag;
  logic [ENTRY_BITS-1:0]     issue_id;
  logic                      fill_valid;
  logic                      fill_ready;
  logic [ENTRY_BITS-1:0]     fill_id;
  logic                      replay_valid;
  logic                      replay_ready;
  logic [TAG_BITS-1:0]       replay_tag;
  logic [DATA_BITS-1:0]      replay_data;
  logic                      replay_rw;
  logic                      replay_last;
  logic [TAG_BITS-1:0]       lookup_tag;
  logic                      lookup_hit;
  logic                      lookup_rw;
  logic [ENTRY_BITS:0]       occupancy;
  logic                      fill_err;
  logic [2*(1<<ENTRY_BITS)-1:0] dbg_entry_state;

  modport slave (
    input  alloc_valid, alloc_tag, alloc_data, alloc_rw, issue_ready,
           fill_valid, fill_id, replay_ready, lookup_tag,
    output alloc_ready, alloc_id, issue_valid, issue_tag, issue_id, fill_ready,
           replay_valid, replay_tag, replay_data, replay_rw, replay_last,
           lookup_hit, lookup_rw, occupancy, fill_err, dbg_entry_state
  );

  modport master (
    output alloc_valid, alloc_tag, alloc_data, alloc_rw, issue_ready,
           fill_valid, fill_id, replay_ready, lookup_tag,
    input  alloc_ready, alloc_id, issue_valid, issue_tag, issue_id, fill_ready,
           replay_valid, replay_tag, replay_data, replay_rw, replay_last,
           lookup_hit, lookup_rw, occupancy, fill_err, dbg_entry_state
  );
endinterface

// File: rtl/mshr_merge_queue.sv
// Miss status holding register with in-order issue and per-entry target replay.
// Define MSHR_MERGE_EN to let secondary misses merge into an in-flight entry.
module mshr_merge_queue #(
  parameter int TAG_BITS    = 20,
  parameter int DATA_BITS   = 90,
  parameter int ENTRY_BITS  = 3,
  parameter int TARGET_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  mshr_merge_queue_if.slave   mq
);
  localparam int N  = 1 << ENTRY_BITS;
`ifdef MSHR_MERGE_EN
  localparam int T  = 1 << TARGET_BITS;
`else
  localparam int T  = 1;
`endif
  localparam int CW = TARGET_BITS + 1;
  localparam int OW = ENTRY_BITS + 1;

  typedef enum logic [1:0] {E_FREE, E_PENDING, E_ISSUED, E_FILLING} entry_state_e;

  entry_state_e          r_state     [N];
  entry_state_e          w_state_nxt [N];
  logic [TAG_BITS-1:0]   r_tag       [N];
  logic [CW-1:0]         r_cnt       [N];
  logic [DATA_BITS-1:0]  r_tdata     [N][T];
  logic                  r_trw       [N][T];
  logic [ENTRY_BITS-1:0] r_fifo      [N];
  logic [ENTRY_BITS-1:0] r_wr_ptr, r_rd_ptr;
  logic [OW-1:0]         r_fifo_cnt, r_occ;
  logic                  r_fill_act;
  logic [ENTRY_BITS-1:0] r_fill_id;
  logic [CW-1:0]         r_rp_ptr;
  logic                  r_fill_err;

  logic                  w_match, w_free_ok, w_lk_hit, w_lk_rw;
  logic [ENTRY_BITS-1:0] w_match_id, w_free_id, w_alloc_tgt_id, w_issue_id;
  logic                  w_can_merge, w_alloc_ok, w_alloc_fire, w_alloc_new;
  logic                  w_issue_valid, w_issue_fire, w_fill_fire, w_fill_ok;
  logic                  w_rp_last, w_rp_fire, w_free_fire;
  logic [DATA_BITS-1:0]  w_rp_data;
  logic                  w_rp_rw;

  // Tags are unique among busy entries, so at most one entry can match.
  // Scanning downwards leaves the lowest-index hit in the result.
  always_comb begin
    w_match    = 1'b0;
    w_match_id = '0;
    w_free_ok  = 1'b0;
    w_free_id  = '0;
    w_lk_hit   = 1'b0;
    w_lk_rw    = 1'b0;
    for (int i = N-1; i >= 0; i--) begin
      if (r_state[i] == E_FREE) begin
        w_free_ok = 1'b1;
        w_free_id = ENTRY_BITS'(i);
      end
      if (r_state[i] != E_FREE && r_tag[i] == mq.alloc_tag) begin
        w_match    = 1'b1;
        w_match_id = ENTRY_BITS'(i);
      end
      if (r_state[i] != E_FREE && r_tag[i] == mq.lookup_tag) begin
        w_lk_hit = 1'b1;
        for (int j = 0; j < T; j++)
          if (CW'(j) < r_cnt[i]) w_lk_rw = w_lk_rw | r_trw[i][j];
      end
    end
  end

`ifdef MSHR_MERGE_EN
  assign w_can_merge = (r_state[w_match_id] != E_FILLING) && (r_cnt[w_match_id] < CW'(T));
  assign w_rp_last   = (r_rp_ptr == r_cnt[r_fill_id] - CW'(1));
`else
  assign w_can_merge = 1'b0;
  assign w_rp_last   = 1'b1;
`endif

  assign w_alloc_ok     = w_match ? w_can_merge : w_free_ok;
  assign w_alloc_fire   = mq.alloc_valid && w_alloc_ok;
  assign w_alloc_new    = w_alloc_fire && !w_match;
  assign w_alloc_tgt_id = w_match ? w_match_id : w_free_id;

  assign w_issue_valid  = (r_fifo_cnt != '0);
  assign w_issue_id     = r_fifo[r_rd_ptr];
  assign w_issue_fire   = w_issue_valid && mq.issue_ready;

  assign w_fill_fire    = mq.fill_valid && !r_fill_act;
  assign w_fill_ok      = w_fill_fire && (r_state[mq.fill_id] == E_ISSUED);

  assign w_rp_fire      = r_fill_act && mq.replay_ready;
  assign w_free_fire    = w_rp_fire && w_rp_last;

  always_comb begin
    w_rp_data = '0;
    w_rp_rw   = 1'b0;
    for (int j = 0; j < T; j++) begin
      if (CW'(j) == r_rp_ptr) begin
        w_rp_data = r_tdata[r_fill_id][j];
        w_rp_rw   = r_trw[r_fill_id][j];
      end
    end
  end

  // Per-entry lifecycle: FREE -> PENDING -> ISSUED -> FILLING -> FREE.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        E_FREE:    if (w_alloc_new && w_free_id == ENTRY_BITS'(i))  w_state_nxt[i] = E_PENDING;
        E_PENDING: if (w_issue_fire && w_issue_id == ENTRY_BITS'(i)) w_state_nxt[i] = E_ISSUED;
        E_ISSUED:  if (w_fill_ok && mq.fill_id == ENTRY_BITS'(i))   w_state_nxt[i] = E_FILLING;
        E_FILLING: if (w_free_fire && r_fill_id == ENTRY_BITS'(i))  w_state_nxt[i] = E_FREE;
        default:   w_state_nxt[i] = E_FREE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= E_FREE;
        r_tag[i]   <= '0;
        r_cnt[i]   <= '0;
        r_fifo[i]  <= '0;
        for (int j = 0; j < T; j++) begin
          r_tdata[i][j] <= '0;
          r_trw[i][j]   <= 1'b0;
        end
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_occ      <= '0;
      r_fill_act <= 1'b0;
      r_fill_id  <= '0;
      r_rp_ptr   <= '0;
      r_fill_err <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) r_state[i] <= w_state_nxt[i];

      if (w_alloc_fire) begin
        for (int j = 0; j < T; j++) begin
          if (CW'(j) == r_cnt[w_alloc_tgt_id]) begin
            r_tdata[w_alloc_tgt_id][j] <= mq.alloc_data;
            r_trw[w_alloc_tgt_id][j]   <= mq.alloc_rw;
          end
        end
        r_cnt[w_alloc_tgt_id] <= r_cnt[w_alloc_tgt_id] + CW'(1);
        if (!w_match) begin
          r_tag[w_free_id]  <= mq.alloc_tag;
          r_fifo[r_wr_ptr]  <= w_free_id;
          r_wr_ptr          <= r_wr_ptr + ENTRY_BITS'(1);
        end
      end

      if (w_issue_fire) r_rd_ptr <= r_rd_ptr + ENTRY_BITS'(1);
      r_fifo_cnt <= r_fifo_cnt + OW'(w_alloc_new) - OW'(w_issue_fire);
      r_occ      <= r_occ + OW'(w_alloc_new) - OW'(w_free_fire);

      if (w_fill_fire) begin
        if (w_fill_ok) begin
          r_fill_act <= 1'b1;
          r_fill_id  <= mq.fill_id;
          r_rp_ptr   <= '0;
        end else begin
          r_fill_err <= 1'b1;
        end
      end

      // A freed entry never overlaps an alloc target: FILLING entries refuse allocs.
      if (w_rp_fire) begin
        if (w_rp_last) begin
          r_fill_act       <= 1'b0;
          r_tag[r_fill_id] <= '0;
          r_cnt[r_fill_id] <= '0;
        end else begin
          r_rp_ptr <= r_rp_ptr + CW'(1);
        end
      end
    end
  end

  assign mq.alloc_ready  = w_alloc_ok;
  assign mq.alloc_id     = w_alloc_tgt_id;
  assign mq.issue_valid  = w_issue_valid;
  assign mq.issue_tag    = w_issue_valid ? r_tag[w_issue_id] : '0;
  assign mq.issue_id     = w_issue_valid ? w_issue_id : '0;
  assign mq.fill_ready   = !r_fill_act;
  assign mq.replay_valid = r_fill_act;
  assign mq.replay_tag   = r_fill_act ? r_tag[r_fill_id] : '0;
  assign mq.replay_data  = r_fill_act ? w_rp_data : '0;
  assign mq.replay_rw    = r_fill_act && w_rp_rw;
  assign mq.replay_last  = r_fill_act && w_rp_last;
  assign mq.lookup_hit   = w_lk_hit;
  assign mq.lookup_rw    = w_lk_rw;
  assign mq.occupancy    = r_occ;
  assign mq.fill_err     = r_fill_err;

  always_comb begin
    mq.dbg_entry_state = '0;
    for (int i = 0; i < N; i++) mq.dbg_entry_state[2*i +: 2] = r_state[i];
  end
endmodule

// File: tb/tb_mshr_merge_queue.sv
// Directed bench for mshr_merge_queue: drivers push expected issues/replays,
// negedge monitors pop and compare whenever the DUT completes a handshake.
module tb_mshr_merge_queue;
  localparam int TAG_BITS    = 20;
  localparam int DATA_BITS   = 90;
  localparam int ENTRY_BITS  = 3;
  localparam int TARGET_BITS = 2;
  localparam int IW = TAG_BITS + ENTRY_BITS;
  localparam int RW = TAG_BITS + DATA_BITS + 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mshr_merge_queue_if #(.TAG_BITS(TAG_BITS), .DATA_BITS(DATA_BITS), .ENTRY_BITS(ENTRY_BITS)) mq();

  mshr_merge_queue #(
    .TAG_BITS(TAG_BITS), .DATA_BITS(DATA_BITS),
    .ENTRY_BITS(ENTRY_BITS), .TARGET_BITS(TARGET_BITS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mq(mq)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [IW-1:0] iss_q[$];
  logic [RW-1:0] exp_q[$];
  logic [IW-1:0] iss_e;
  logic [RW-1:0] rp_e;

  logic [TAG_BITS-1:0]  mdl_tag  [8];
  int                   mdl_cnt  [8];
  logic [DATA_BITS-1:0] mdl_data [8][4];
  logic                 mdl_rw   [8][4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_BITS-1:0] mk_data(input logic [TAG_BITS-1:0] tag, input int k);
    return {tag, 62'h0, 8'(k)};
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (reset && mq.issue_valid && mq.issue_ready) begin
      if (iss_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL issue_unexpected: got tag %0h id %0d, none required", mq.issue_tag, mq.issue_id);
      end else begin
        iss_e = iss_q.pop_front();
        check("issue", 128'({mq.issue_tag, mq.issue_id}), 128'(iss_e));
      end
    end
  end

  always @(negedge clk) begin
    if (reset && mq.replay_valid && mq.replay_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL replay_unexpected: got tag %0h data %0h, none required", mq.replay_tag, mq.replay_data);
      end else begin
        rp_e = exp_q.pop_front();
        check("replay", 128'({mq.replay_tag, mq.replay_data, mq.replay_rw, mq.replay_last}), 128'(rp_e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_alloc(input logic [TAG_BITS-1:0] tag, input logic rw, input int exp_id, input bit is_new);
    int k;
    @(posedge clk); #1;
    if (is_new) begin mdl_tag[exp_id] = tag; mdl_cnt[exp_id] = 0; end
    k = mdl_cnt[exp_id];
    mq.alloc_valid = 1'b1;
    mq.alloc_tag   = tag;
    mq.alloc_data  = mk_data(tag, k);
    mq.alloc_rw    = rw;
    @(negedge clk);
    check("alloc_ready", 128'(mq.alloc_ready), 128'(1));
    check("alloc_id", 128'(mq.alloc_id), 128'(exp_id));
    @(posedge clk); #1;
    mq.alloc_valid = 1'b0;
    mdl_data[exp_id][k] = mk_data(tag, k);
    mdl_rw[exp_id][k]   = rw;
    mdl_cnt[exp_id]     = k + 1;
    if (is_new) iss_q.push_back({tag, ENTRY_BITS'(exp_id)});
  endtask

  task automatic alloc_blocked(input string name, input logic [TAG_BITS-1:0] tag);
    @(posedge clk); #1;
    mq.alloc_valid = 1'b1;
    mq.alloc_tag   = tag;
    mq.alloc_data  = mk_data(tag, 99);
    mq.alloc_rw    = 1'b0;
    @(negedge clk);
    check(name, 128'(mq.alloc_ready), 128'(0));
    @(posedge clk); #1;
    mq.alloc_valid = 1'b0;
  endtask

  task automatic do_fill(input int id, input bit ok);
    int t;
    t = 0;
    @(posedge clk); #1;
    mq.fill_valid = 1'b1;
    mq.fill_id    = ENTRY_BITS'(id);
    @(negedge clk);
    while (!mq.fill_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!mq.fill_ready) begin
      n_cmp++; n_err++;
      $display("FAIL fill_timeout: fill_ready got 0 for 60 cycles, required 1 (id %0d)", id);
      mq.fill_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    mq.fill_valid = 1'b0;
    if (ok) begin
      for (int j = 0; j < mdl_cnt[id]; j++)
        exp_q.push_back({mdl_tag[id], mdl_data[id][j], mdl_rw[id][j], (j == mdl_cnt[id] - 1)});
      mdl_cnt[id] = 0;
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || iss_q.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || iss_q.size() != 0) begin
      n_err++;
      $display("FAIL %s: got %0d replays and %0d issues outstanding, required 0", name, exp_q.size(), iss_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    mq.alloc_valid  = 1'b0;
    mq.alloc_tag    = '0;
    mq.alloc_data   = '0;
    mq.alloc_rw     = 1'b0;
    mq.issue_ready  = 1'b1;
    mq.fill_valid   = 1'b0;
    mq.fill_id      = '0;
    mq.replay_ready = 1'b1;
    mq.lookup_tag   = 20'h00AB5;
    for (int i = 0; i < 8; i++) mdl_cnt[i] = 0;

    // reset values while reset is held
    repeat (3) @(negedge clk);
    check("rst_alloc_ready", 128'(mq.alloc_ready), 128'(1));
    check("rst_alloc_id", 128'(mq.alloc_id), 128'(0));
    check("rst_fill_ready", 128'(mq.fill_ready), 128'(1));
    check("rst_issue_valid", 128'(mq.issue_valid), 128'(0));
    check("rst_replay_valid", 128'(mq.replay_valid), 128'(0));
    check("rst_occupancy", 128'(mq.occupancy), 128'(0));
    check("rst_fill_err", 128'(mq.fill_err), 128'(0));
    check("rst_lookup_hit", 128'(mq.lookup_hit), 128'(0));
    check("rst_dbg_state", 128'(mq.dbg_entry_state), 128'(0));
    reset = 1'b1;

    // first miss: entry 0, issued the following cycle
    do_alloc(20'h00AB5, 1'b0, 0, 1'b1);
    @(negedge clk);
    check("occ_after_alloc", 128'(mq.occupancy), 128'(1));
    check("issue_valid_n1", 128'(mq.issue_valid), 128'(1));
    check("issue_tag_n1", 128'(mq.issue_tag), 128'(20'h00AB5));
    check("issue_id_n1", 128'(mq.issue_id), 128'(0));

`ifdef MSHR_MERGE_EN
    do_alloc(20'h00AB5, 1'b1, 0, 1'b0);
    do_alloc(20'h00AB5, 1'b0, 0, 1'b0);
    do_alloc(20'h00AB5, 1'b0, 0, 1'b0);
    @(negedge clk);
    check("lookup_hit_merged", 128'(mq.lookup_hit), 128'(1));
    check("lookup_rw_merged", 128'(mq.lookup_rw), 128'(1));
    check("occ_merged", 128'(mq.occupancy), 128'(1));
    alloc_blocked("alloc_targets_full", 20'h00AB5);
`else
    @(negedge clk);
    check("lookup_hit_single", 128'(mq.lookup_hit), 128'(1));
    check("lookup_rw_single", 128'(mq.lookup_rw), 128'(0));
    alloc_blocked("alloc_dup_tag", 20'h00AB5);
`endif
    mq.lookup_tag = 20'h12345;
    @(negedge clk);
    check("lookup_miss_hit", 128'(mq.lookup_hit), 128'(0));
    check("lookup_miss_rw", 128'(mq.lookup_rw), 128'(0));

    do_fill(0, 1'b1);
    wait_drain("drain_entry0");
    @(negedge clk);
    check("occ_after_replay0", 128'(mq.occupancy), 128'(0));

    // fill all eight entries while memory stalls
    mq.issue_ready = 1'b0;
    for (int i = 0; i < 8; i++) do_alloc(20'h00010 + 20'(i), 1'(i & 1), i, 1'b1);
    @(negedge clk);
    check("occ_full", 128'(mq.occupancy), 128'(8));
    alloc_blocked("alloc_no_free", 20'h00099);

    do_fill(3, 1'b0);
    @(negedge clk);
    check("fill_err_pending", 128'(mq.fill_err), 128'(1));
    check("dbg_e3_pending", 128'(mq.dbg_entry_state[7:6]), 128'(2'b01));
    check("occ_after_bad_fill", 128'(mq.occupancy), 128'(8));

    mq.issue_ready = 1'b1;
    wait_drain("issue_order");

    // entry 5 frees at the last replay edge and is reallocated one cycle later
    do_fill(5, 1'b1);
    mq.alloc_valid = 1'b1;
    mq.alloc_tag   = 20'h00055;
    mq.alloc_data  = mk_data(20'h00055, 0);
    mq.alloc_rw    = 1'b1;
    @(negedge clk);
    check("realloc_wait", 128'(mq.alloc_ready), 128'(0));
    @(negedge clk);
    check("realloc_ready", 128'(mq.alloc_ready), 128'(1));
    check("realloc_id", 128'(mq.alloc_id), 128'(5));
    @(posedge clk); #1;
    mq.alloc_valid = 1'b0;
    mdl_tag[5] = 20'h00055; mdl_data[5][0] = mk_data(20'h00055, 0); mdl_rw[5][0] = 1'b1; mdl_cnt[5] = 1;
    iss_q.push_back({20'h00055, 3'd5});
    wait_drain("reissue5");

    for (int i = 0; i < 8; i++) do_fill(i, 1'b1);
    wait_drain("drain_all");
    @(negedge clk);
    check("occ_empty", 128'(mq.occupancy), 128'(0));

    // replay back-pressure stalls the next fill
`ifdef MSHR_MERGE_EN
    do_alloc(20'h000A1, 1'b0, 0, 1'b1);
    do_alloc(20'h000A1, 1'b1, 0, 1'b0);
    do_alloc(20'h000A1, 1'b0, 0, 1'b0);
`else
    do_alloc(20'h000A1, 1'b0, 0, 1'b1);
`endif
    do_alloc(20'h000B2, 1'b1, 1, 1'b1);
    mq.replay_ready = 1'b0;
    do_fill(0, 1'b1);
`ifdef MSHR_MERGE_EN
    mq.replay_ready = 1'b1;
    @(posedge clk); #1;
    mq.replay_ready = 1'b0;
`endif
    mq.fill_valid = 1'b1;
    mq.fill_id    = 3'd1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_fill_ready", 128'(mq.fill_ready), 128'(0));
      check("stall_replay_valid", 128'(mq.replay_valid), 128'(1));
    end
    @(posedge clk); #1;
    mq.fill_valid   = 1'b0;
    mq.replay_ready = 1'b1;
    do_fill(1, 1'b1);
    wait_drain("drain_stall");

    // reset in the middle of a replay with four entries busy
    for (int i = 0; i < 4; i++) do_alloc(20'h000C0 + 20'(i), 1'b0, i, 1'b1);
    mq.replay_ready = 1'b0;
    do_fill(0, 1'b1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("midrst_occupancy", 128'(mq.occupancy), 128'(0));
    check("midrst_replay_valid", 128'(mq.replay_valid), 128'(0));
    check("midrst_alloc_ready", 128'(mq.alloc_ready), 128'(1));
    check("midrst_issue_valid", 128'(mq.issue_valid), 128'(0));
    exp_q.delete();
    iss_q.delete();
    for (int i = 0; i < 8; i++) mdl_cnt[i] = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mq.replay_ready = 1'b1;
    @(negedge clk);
    check("postrst_fill_err", 128'(mq.fill_err), 128'(0));

    do_alloc(20'h000D0, 1'b1, 0, 1'b1);
    do_fill(0, 1'b1);
    wait_drain("drain_postrst");
    @(negedge clk);
    check("occ_final", 128'(mq.occupancy), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
